// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU and LSU result handshakes plus the register file write port.
interface wb_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(ALU_FIFO_DEPTH) + 1;

  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [4:0]            alu_addr_i;
  logic [DATA_WIDTH-1:0] alu_data_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [4:0]            lsu_addr_i;
  logic [DATA_WIDTH-1:0] lsu_data_i;
  logic [4:0]            w_addr_o;
  logic [DATA_WIDTH-1:0] din_o;
  logic [CNT_W-1:0]      fifo_cnt_o;

  modport master (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    output alu_ready_o, lsu_ready_o, w_addr_o, din_o, fifo_cnt_o
  );

  modport slave (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  alu_ready_o, lsu_ready_o, w_addr_o, din_o, fifo_cnt_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results into one register file write per cycle.
// Optional pending-register scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  wb_arbiter_if.master bus
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic       mark_valid_i,
  input  logic [4:0] mark_addr_i,
  input  logic [4:0] q1_addr_i,
  input  logic [4:0] q2_addr_i,
  output logic       q1_busy_o,
  output logic       q2_busy_o
`endif
);
  localparam int PTR_W = $clog2(ALU_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ALU_FIFO_DEPTH);

  typedef enum logic [1:0] {SEL_IDLE, SEL_POP, SEL_LSU, SEL_ALU} sel_t;

  logic [4:0]            fifo_addr [ALU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [ALU_FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [4:0]            w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  full, empty, push, pop;
  sel_t                  sel;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  assign bus.alu_ready_o = ~full;
  assign bus.lsu_ready_o = ~full;
  assign bus.w_addr_o    = w_addr_q;
  assign bus.din_o       = din_q;
  assign bus.fifo_cnt_o  = cnt;

  // Full FIFO drains first so the LSU can never starve buffered ALU results.
  always_comb begin
    sel = SEL_IDLE;
    if (full)                 sel = SEL_POP;
    else if (bus.lsu_valid_i) sel = SEL_LSU;
    else if (!empty)          sel = SEL_POP;
    else if (bus.alu_valid_i) sel = SEL_ALU;
  end

  assign pop  = (sel == SEL_POP);
  assign push = bus.alu_valid_i & ~full & (sel != SEL_ALU);

  always_comb begin
    w_addr_d = '0;
    din_d    = '0;
    case (sel)
      SEL_POP: begin
        w_addr_d = fifo_addr[rd_ptr];
        din_d    = fifo_data[rd_ptr];
      end
      SEL_LSU: begin
        w_addr_d = bus.lsu_addr_i;
        din_d    = bus.lsu_data_i;
      end
      SEL_ALU: begin
        w_addr_d = bus.alu_addr_i;
        din_d    = bus.alu_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_addr_q <= '0;
      din_q    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      w_addr_q <= w_addr_d;
      din_q    <= din_d;
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.alu_addr_i;
      fifo_data[wr_ptr] <= bus.alu_data_i;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [30:0] pending, clr_mask, mark_mask;
  logic [31:0] pend_ext;

  always_comb begin
    clr_mask  = '0;
    mark_mask = '0;
    if (w_addr_q != 5'd0)                    clr_mask  = 31'(1) << (w_addr_q - 5'd1);
    if (mark_valid_i && mark_addr_i != 5'd0) mark_mask = 31'(1) << (mark_addr_i - 5'd1);
  end

  // Mark is OR-ed after the clear so a same-cycle re-issue keeps the bit set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pending <= '0;
    else          pending <= (pending & ~clr_mask) | mark_mask;
  end

  assign pend_ext  = {pending, 1'b0};
  assign q1_busy_o = pend_ext[q1_addr_i];
  assign q2_busy_o = pend_ext[q2_addr_i];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default build; scoreboard checks when WB_SCOREBOARD_EN is defined).
module tb_wb_arbiter;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter_if #(.DATA_WIDTH(32), .ALU_FIFO_DEPTH(2)) bus ();

`ifdef WB_SCOREBOARD_EN
  logic       mark_valid_i = 1'b0;
  logic [4:0] mark_addr_i  = '0;
  logic [4:0] q1_addr_i    = '0;
  logic [4:0] q2_addr_i    = '0;
  logic       q1_busy_o, q2_busy_o;
`endif

  wb_arbiter #(.DATA_WIDTH(32), .ALU_FIFO_DEPTH(2)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
`ifdef WB_SCOREBOARD_EN
    ,
    .mark_valid_i (mark_valid_i),
    .mark_addr_i  (mark_addr_i),
    .q1_addr_i    (q1_addr_i),
    .q2_addr_i    (q2_addr_i),
    .q1_busy_o    (q1_busy_o),
    .q2_busy_o    (q2_busy_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.alu_valid_i = av;
    bus.alu_addr_i  = aa;
    bus.alu_data_i  = ad;
    bus.lsu_valid_i = lv;
    bus.lsu_addr_i  = la;
    bus.lsu_data_i  = ld;
  endtask

  task automatic wcheck(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [1:0] c);
    chk({tag, ".addr"}, 64'(bus.w_addr_o), 64'(a));
    chk({tag, ".din"},  64'(bus.din_o),    64'(d));
    chk({tag, ".cnt"},  64'(bus.fifo_cnt_o), 64'(c));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #2;
    wcheck("reset", 5'd0, 32'd0, 2'd0);
    chk("reset.alu_rdy", 64'(bus.alu_ready_o), 64'd1);
    chk("reset.lsu_rdy", 64'(bus.lsu_ready_o), 64'd1);
    #1 rst_n_i = 1'b1;
    step();

    // direct ALU path
    drive(1, 5'd5, 32'h9, 0, 0, 0);
    step();
    wcheck("direct", 5'd5, 32'h9, 2'd0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    wcheck("idle", 5'd0, 32'd0, 2'd0);

    // ALU and LSU conflict
    drive(1, 5'd7, 32'h11, 1, 5'd4, 32'h22);
    step();
    wcheck("conflict.lsu", 5'd4, 32'h22, 2'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    wcheck("conflict.alu", 5'd7, 32'h11, 2'd0);

    // fill FIFO under continuous LSU traffic
    drive(1, 5'd1, 32'h101, 1, 5'd10, 32'hA0);
    step();
    wcheck("fill.a", 5'd10, 32'hA0, 2'd1);
    drive(1, 5'd2, 32'h102, 1, 5'd11, 32'hA1);
    step();
    wcheck("fill.b", 5'd11, 32'hA1, 2'd2);
    drive(1, 5'd3, 32'h103, 1, 5'd12, 32'hA2);
    chk("full.lsu_rdy", 64'(bus.lsu_ready_o), 64'd0);
    chk("full.alu_rdy", 64'(bus.alu_ready_o), 64'd0);
    step();
    wcheck("full.pop1", 5'd1, 32'h101, 2'd1);
    chk("drain.lsu_rdy", 64'(bus.lsu_ready_o), 64'd1);
    step();
    wcheck("full.lsu12", 5'd12, 32'hA2, 2'd2);
    drive(0, 0, 0, 0, 0, 0);
    step();
    wcheck("full.pop2", 5'd2, 32'h102, 2'd1);
    step();
    wcheck("full.pop3", 5'd3, 32'h103, 2'd0);

    // address 0 result
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    chk("addr0.rdy", 64'(bus.alu_ready_o), 64'd1);
    step();
    wcheck("addr0", 5'd0, 32'hFFFF_FFFF, 2'd0);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // reset while FIFO holds two entries
    drive(1, 5'd20, 32'h200, 1, 5'd13, 32'hB0);
    step();
    drive(1, 5'd21, 32'h201, 1, 5'd14, 32'hB1);
    step();
    wcheck("prerst", 5'd14, 32'hB1, 2'd2);
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_n_i = 1'b0;
    #1;
    wcheck("midrst", 5'd0, 32'd0, 2'd0);
    #1 rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      wcheck($sformatf("postrst%0d", i), 5'd0, 32'd0, 2'd0);
    end

`ifdef WB_SCOREBOARD_EN
    q1_addr_i = 5'd6;
    q2_addr_i = 5'd0;
    mark_valid_i = 1'b1; mark_addr_i = 5'd6;
    step();
    mark_valid_i = 1'b0;
    chk("sb.marked", 64'(q1_busy_o), 64'd1);
    chk("sb.q0", 64'(q2_busy_o), 64'd0);
    drive(1, 5'd6, 32'h66, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("sb.wcycle_addr", 64'(bus.w_addr_o), 64'd6);
    step();
    chk("sb.cleared", 64'(q1_busy_o), 64'd0);
    mark_valid_i = 1'b1; mark_addr_i = 5'd6;
    step();
    drive(1, 5'd6, 32'h67, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("sb.wcycle2", 64'(bus.w_addr_o), 64'd6);
    step();
    mark_valid_i = 1'b0;
    chk("sb.markwins", 64'(q1_busy_o), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
